// File: rtl/lut_pkg.sv
// Shared types and sizing for the target-encoder LUT.
// Entries hold signed PC offsets / data addresses.
package lut_pkg;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int OUT_W   = 11;

    typedef logic [IDX_W-1:0]        lut_idx_t;
    typedef logic signed [OUT_W-1:0] lut_val_t;

    localparam lut_val_t FILL = lut_val_t'(1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        RESP
    } lut_enc_state_t;

endpackage

// File: rtl/lut_target_encoder_regfile.sv
// ENTRIES x OUT_W storage, one write port, two async read ports.
// Every entry returns to FILL on reset.
module lut_regfile
    import lut_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_we,
    input  lut_idx_t i_wr_idx,
    input  lut_val_t i_wr_data,
    input  lut_idx_t i_rd_idx_a,
    output lut_val_t o_rd_data_a,
    input  lut_idx_t i_rd_idx_b,
    output lut_val_t o_rd_data_b
);

    lut_val_t r_mem [ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_mem[i] <= FILL;
            end
        end else if (i_we) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data_a = r_mem[i_rd_idx_a];
    assign o_rd_data_b = r_mem[i_rd_idx_b];

endmodule

// File: rtl/lut_target_encoder.sv
// Reverse lookup over a programmable LUT: scans one entry per clock
// from index 0 upward and reports the first index equal to the target.
module lut_target_encoder
    import lut_pkg::*;
(
    input  logic     Clk,
    input  logic     Reset,
    input  logic     WrEn,
    input  lut_idx_t WrIndex,
    input  lut_val_t WrData,
    input  lut_idx_t RdIndex,
    output lut_val_t RdData,
    input  logic     ReqValid,
    input  lut_val_t ReqTarget,
    output logic     ReqReady,
    output logic     RespValid,
    output logic     RespHit,
    output lut_idx_t RespIndex,
    input  logic     RespReady,
    output logic     Busy
);

    lut_enc_state_t r_state;
    lut_enc_state_t w_state_nxt;
    lut_idx_t       r_ptr;
    lut_idx_t       w_ptr_nxt;
    lut_idx_t       r_idx;
    lut_idx_t       w_idx_nxt;
    lut_val_t       r_target;
    lut_val_t       w_target_nxt;
    logic           r_hit;
    logic           w_hit_nxt;
    lut_val_t       w_cmp_data;
    logic           w_match;
    logic           w_last;

    lut_regfile u_regfile (
        .clk        (Clk),
        .rst        (Reset),
        .i_we       (WrEn),
        .i_wr_idx   (WrIndex),
        .i_wr_data  (WrData),
        .i_rd_idx_a (RdIndex),
        .o_rd_data_a(RdData),
        .i_rd_idx_b (r_ptr),
        .o_rd_data_b(w_cmp_data)
    );

    // A write landing on r_ptr this cycle only takes effect at the edge,
    // so the compare naturally sees the old value.
    assign w_match = (w_cmp_data == r_target);
    assign w_last  = (r_ptr == lut_idx_t'(ENTRIES - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_target <= '0;
            r_hit    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_idx    <= w_idx_nxt;
            r_target <= w_target_nxt;
            r_hit    <= w_hit_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_idx_nxt    = r_idx;
        w_target_nxt = r_target;
        w_hit_nxt    = r_hit;
        unique case (r_state)
            IDLE: begin
                if (ReqValid) begin
                    w_state_nxt  = SEARCH;
                    w_target_nxt = ReqTarget;
                    w_ptr_nxt    = '0;
                    w_hit_nxt    = 1'b0;
                    w_idx_nxt    = '0;
                end
            end
            SEARCH: begin
                if (w_match) begin
                    w_state_nxt = RESP;
                    w_hit_nxt   = 1'b1;
                    w_idx_nxt   = r_ptr;
                end else if (w_last) begin
                    w_state_nxt = RESP;
                    w_hit_nxt   = 1'b0;
                    w_idx_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + lut_idx_t'(1);
                end
            end
            RESP: begin
                if (RespReady) begin
                    w_state_nxt = IDLE;
                    w_hit_nxt   = 1'b0;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ReqReady  = (r_state == IDLE);
    assign RespValid = (r_state == RESP);
    assign Busy      = (r_state != IDLE);
    assign RespHit   = r_hit;
    assign RespIndex = r_idx;

endmodule
